// File: rtl/arith_pkg.sv
// Shared definitions for the pipelined add/subtract datapath.
//   DEF_WIDTH / DEF_SEG_W : default operand width and bits resolved per stage
//   mode_e                : operation select carried on in_sub (ADD / SUB)
//   calc_stages()         : pipeline depth for a given width and segment size
package arith_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG_W = 4;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  function automatic int calc_stages(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/seg_adder.sv
// Combinational SEG_W-bit ripple adder built from full-adder cells.
//   a, b : segment operands
//   cin  : carry into bit 0
//   s    : segment sum
//   cout : carry out of the top bit
module seg_adder
  import arith_pkg::*;
#(
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout
);

  // The carry ripples through a single variable so the chain is one
  // evaluation rather than a vector that feeds back into itself.
  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < SEG_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, one SEG_W-bit segment per stage.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake; in_ready drops while the output stalls
//   in_a, in_b          : operands
//   in_cin              : carry-in for add, borrow-in for subtract
//   in_sub              : 0 = A+B+cin, 1 = A-B-cin
//   out_valid/out_ready : result handshake with backpressure
//   out_sum             : result, wraps modulo 2^WIDTH
//   out_cout            : carry out of the top segment (subtract: 1 = no borrow)
//   out_ovf             : two's-complement signed overflow
// Latency is STAGES cycles of the pipeline (beat accepted at edge N is
// presented after edge N+STAGES-1); throughput one beat per cycle.
module pipelined_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG_W = DEF_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = calc_stages(WIDTH, SEG_W);
  localparam int LAST   = STAGES - 1;

  if (SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_bad_width
    $error("pipelined_addsub: WIDTH must be a positive multiple of SEG_W");
  end

  // Pipeline registers, one slot per stage. a_q/b_q forward the operand
  // words; only the segments above the current stage are still consumed,
  // plus the MSBs needed for the overflow decision at the output.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] valid_q;

  logic [WIDTH-1:0]  a_d      [STAGES];
  logic [WIDTH-1:0]  b_d      [STAGES];
  logic [WIDTH-1:0]  sum_prev [STAGES];
  logic [WIDTH-1:0]  sum_d    [STAGES];
  logic [STAGES-1:0] cin_st;
  logic [STAGES-1:0] carry_d;
  logic [STAGES-1:0] valid_d;
  logic [SEG_W-1:0]  seg_s    [STAGES];

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Subtract is A + ~B + ~borrow, so the same adder serves both modes.
  always_comb begin
    b_eff = in_b;
    c0    = in_cin;
    if (in_sub == SUB) begin
      b_eff = ~in_b;
      c0    = ~in_cin;
    end
  end

  // What each stage sees: stage 0 takes the prepared operands, later
  // stages take the previous stage's registers. A cycle with no input beat
  // enters as valid=0, so bubbles flow through instead of collapsing.
  always_comb begin
    a_d[0]      = in_a;
    b_d[0]      = b_eff;
    sum_prev[0] = '0;
    cin_st      = '0;
    valid_d     = '0;
    cin_st[0]   = c0;
    valid_d[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]      = a_q[k-1];
      b_d[k]      = b_q[k-1];
      sum_prev[k] = sum_q[k-1];
      cin_st[k]   = carry_q[k-1];
      valid_d[k]  = valid_q[k-1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    seg_adder #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a    (a_d[gi][gi*SEG_W +: SEG_W]),
      .b    (b_d[gi][gi*SEG_W +: SEG_W]),
      .cin  (cin_st[gi]),
      .s    (seg_s[gi]),
      .cout (carry_d[gi])
    );
  end

  // Merge the freshly resolved segment into the partial sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]                    = sum_prev[k];
      sum_d[k][k*SEG_W +: SEG_W]  = seg_s[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      carry_q <= '0;
      valid_q <= '0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = carry_q[LAST];
  // Overflow from the MSBs that travelled with the beat; all-zero after reset.
  assign out_ovf   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                     (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  localparam int W   = 16;
  localparam int SW  = 4;
  localparam int LAT = W / SW;   // pipeline depth

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pops   = 0;
  exp_t sb[$];

  pipelined_addsub #(.WIDTH(W), .SEG_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the stated rules.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    int ua, ub, sa, sbv, ci, r, sr;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    ci  = int'(cin);
    if (!sub) begin
      r      = ua + ub + ci;
      sr     = sa + sbv + ci;
      e.cout = (r > 65535);
    end else begin
      r      = ua - ub - ci;
      sr     = sa - sbv - ci;
      e.cout = (r >= 0);
    end
    e.sum = W'(r);
    e.ovf = (sr > 32767) || (sr < -32768);
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub, input bit lat);
    exp_t e;
    bit   done;
    done     = 1'b0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(a, b, cin, sub);
        e.acc = cyc + 1;
        e.lat = lat;
        sb.push_back(e);
        done  = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk(1'b0, "send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(sb.size() == 0, "drain_timeout", sb.size(), 0);
  endtask

  // Monitor: compares each handshaken result with the head of the scoreboard
  // and checks that a stalled output holds until it is taken.
  logic         hold_pending = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_cout;
  logic         hold_ovf;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk(out_valid == 1'b1, "stall_hold_valid", int'(out_valid), 1);
        chk(out_sum == hold_sum && out_cout == hold_cout && out_ovf == hold_ovf,
            "stall_hold_data", int'({out_cout, out_ovf, out_sum}),
            int'({hold_cout, hold_ovf, hold_sum}));
      end
      hold_pending = 1'b0;
      if (out_valid) begin
        if (!out_ready) begin
          hold_pending = 1'b1;
          hold_sum     = out_sum;
          hold_cout    = out_cout;
          hold_ovf     = out_ovf;
        end else if (sb.size() == 0) begin
          chk(1'b0, "unexpected_beat", int'(out_sum), 0);
        end else begin
          e = sb.pop_front();
          pops++;
          $display("beat %0d: sum=0x%04h cout=%0b ovf=%0b (model 0x%04h %0b %0b) cyc=%0d",
                   pops, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf, cyc);
          chk(out_sum == e.sum, "sum", int'(out_sum), int'(e.sum));
          chk(out_cout == e.cout, "cout", int'(out_cout), int'(e.cout));
          chk(out_ovf == e.ovf, "ovf", int'(out_ovf), int'(e.ovf));
          if (e.lat) chk(cyc == e.acc + LAT - 1, "latency", cyc - e.acc, LAT - 1);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p0;
    int  low;
    bit  seen;
    bit  rdone;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0);
    chk(out_sum == '0, "reset_out_sum", int'(out_sum), 0);
    chk(in_ready == 1'b1, "reset_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases, back-to-back, latency checked.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    send(16'h0FFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
    send(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1);
    idle(1);
    drain();

    // Backpressure: 8 back-to-back beats, output stalled 3 cycles at first valid.
    p0   = pops;
    low  = 0;
    seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        in_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 50 && !seen; n++) begin
          @(posedge clk);
          #1;
          if (out_valid) seen = 1'b1;
        end
        chk(seen, "bp_first_valid", int'(seen), 1);
        out_ready = 1'b0;
        for (int n = 0; n < 8; n++) begin
          @(negedge clk);
          if (!in_ready) low++;
          @(posedge clk);
          #1;
          if (n == 2) out_ready = 1'b1;
        end
        chk(low == 3, "bp_in_ready_low_cycles", low, 3);
      end
    join
    drain();
    chk(pops - p0 == 8, "bp_beat_count", pops - p0, 8);

    // Random traffic with random backpressure and input gaps.
    p0    = pops;
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
          if ($urandom_range(0, 2) == 0) idle(1);
        end
        in_valid = 1'b0;
        rdone    = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk(pops - p0 == 40, "rand_beat_count", pops - p0, 40);

    // Reset mid-flight.
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    send(16'h4321, 16'h0001, 1'b1, 1'b1, 1'b0);
    send(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    chk(out_valid == 1'b1, "rst_pre_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
    chk(out_sum == '0, "rst_out_sum", int'(out_sum), 0);
    chk(out_cout == 1'b0, "rst_out_cout", int'(out_cout), 0);
    chk(out_ovf == 1'b0, "rst_out_ovf", int'(out_ovf), 0);
    chk(in_ready == 1'b1, "rst_in_ready", int'(in_ready), 1);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    p0 = pops;
    idle(8);
    chk(pops == p0, "rst_no_stale_beat", pops - p0, 0);
    send(16'hABCD, 16'h1234, 1'b1, 1'b1, 1'b1);
    idle(1);
    drain();
    chk(pops - p0 == 1, "rst_post_beat_count", pops - p0, 1);

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
